// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch/decode sequencer: state encoding, trap
// cause codes and the sequential PC increment.
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_DEC  = 3'd2,
    ST_OUT  = 3'd3,
    ST_TRAP = 3'd4
  } state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b11;

  localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts consecutive un-acked fetch cycles; expired_o flags the cycle in which
// the count would reach TIMEOUT_CYCLES.
module fetch_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Combinational so the trap is taken on the edge that ends the last allowed cycle.
  assign expired_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here
  // would let readers in other always_ff blocks see a half-updated value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode sequencer: owns the PC, fetches over req/ack, filters illegal
// words and hands instructions to execute. Optional perf counters: FETCH_PERF_CNT_EN.
module fetch_decode_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] dec_instruction,
  input  logic        dec_invalid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] trap_pc,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_stall
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        pend_q, pend_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] tpc_q, tpc_d;

  logic        take_trap;
  logic [1:0]  trap_cause_sel;
  logic [31:0] trap_pc_sel;
  logic        redir_misaligned;
  logic        tmo_expired;
  logic        handshake;

  assign redir_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign handshake        = out_valid && out_ready;

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    ((state_q != ST_REQ) || imem_ack),
    .en_i     ((state_q == ST_REQ) && !imem_ack),
    .expired_o(tmo_expired)
  );

  always_comb begin
    // NOTE: every _d gets a default first so no path infers a latch.
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    pend_d         = pend_q;
    cause_d        = cause_q;
    tpc_d          = tpc_q;
    take_trap      = 1'b0;
    trap_cause_sel = CAUSE_NONE;
    trap_pc_sel    = pc_q;

    case (state_q)
      ST_IDLE: if (start) state_d = ST_REQ;

      ST_REQ: begin
        if (imem_ack) instr_d = imem_rdata;
        if (redir_misaligned) begin
          take_trap      = 1'b1;
          trap_cause_sel = CAUSE_MISALIGN;
          trap_pc_sel    = redirect_pc;
        end else begin
          if (redirect_valid) pc_d = redirect_pc;
          if (imem_ack) begin
            // A word fetched before a redirect took effect is stale: re-fetch.
            pend_d  = 1'b0;
            state_d = (redirect_valid || pend_q) ? ST_REQ : ST_DEC;
          end else if (tmo_expired) begin
            take_trap      = 1'b1;
            trap_cause_sel = CAUSE_TIMEOUT;
          end else if (redirect_valid) begin
            pend_d = 1'b1;
          end
        end
      end

      ST_DEC: begin
        if (redir_misaligned) begin
          take_trap      = 1'b1;
          trap_cause_sel = CAUSE_MISALIGN;
          trap_pc_sel    = redirect_pc;
        end else if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = ST_REQ;
        end else if (dec_invalid) begin
          take_trap      = 1'b1;
          trap_cause_sel = CAUSE_ILLEGAL;
        end else begin
          state_d = ST_OUT;
        end
      end

      ST_OUT: begin
        if (redir_misaligned) begin
          take_trap      = 1'b1;
          trap_cause_sel = CAUSE_MISALIGN;
          trap_pc_sel    = redirect_pc;
        end else if (redirect_valid) begin
          // Redirect beats sequential advance even when the word is consumed.
          pc_d    = redirect_pc;
          state_d = ST_REQ;
        end else if (out_ready) begin
          pc_d    = pc_q + PC_INCR;
          state_d = ST_REQ;
        end
      end

      ST_TRAP: begin
        if (start) begin
          pc_d    = RESET_PC;
          cause_d = CAUSE_NONE;
          tpc_d   = '0;
          state_d = ST_REQ;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (take_trap) begin
      state_d = ST_TRAP;
      cause_d = trap_cause_sel;
      tpc_d   = trap_pc_sel;
      pend_d  = 1'b0;
    end
  end

  // The fetch address is frozen while a request is outstanding.
  assign addr_d = ((state_q == ST_REQ) && !imem_ack) ? addr_q : pc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      instr_q <= '0;
      pend_q  <= 1'b0;
      cause_q <= CAUSE_NONE;
      tpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      pend_q  <= pend_d;
      cause_q <= cause_d;
      tpc_q   <= tpc_d;
    end
  end

  assign imem_req        = (state_q == ST_REQ);
  assign imem_addr       = addr_q;
  assign dec_instruction = instr_q;
  assign out_valid       = (state_q == ST_OUT);
  assign out_instruction = instr_q;
  assign out_pc          = out_valid ? pc_q : '0;
  assign trap            = (state_q == ST_TRAP);
  assign trap_cause      = cause_q;
  assign trap_pc         = tpc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_q, stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (handshake && (retired_q != '1))            retired_q <= retired_q + 32'd1;
      if (out_valid && !out_ready && (stall_q != '1)) stall_q   <= stall_q + 32'd1;
    end
  end

  assign perf_retired = retired_q;
  assign perf_stall   = stall_q;
`else
  assign perf_retired = '0;
  assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed bench for fetch_decode_ctrl: per-cycle vector table plus
// hand-written sequences for illegal word, stall, and timeout boundaries.
module tb_fetch_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] dec_instruction;
  logic        dec_invalid;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] perf_retired;
  logic [31:0] perf_stall;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  always #5 clk = ~clk;

  // Stand-in for the RV32 decoder's compressed/illegal detection.
  assign dec_invalid = (dec_instruction[1:0] != 2'b11);

  fetch_decode_ctrl #(
    .RESET_PC      (32'h0000_0000),
    .TIMEOUT_CYCLES(255)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .dec_instruction(dec_instruction),
    .dec_invalid    (dec_invalid),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instruction(out_instruction),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap           (trap),
    .trap_cause     (trap_cause),
    .trap_pc        (trap_pc),
    .perf_retired   (perf_retired),
    .perf_stall     (perf_stall)
  );

  typedef struct {
    logic        start;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_trap;
    logic [1:0]  e_cause;
    logic [31:0] e_tpc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic ack, input logic [31:0] rdata,
                              input logic rdy, input logic rv, input logic [31:0] rpc,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc,
                              input logic e_trap, input logic [1:0] e_cause,
                              input logic [31:0] e_tpc);
    vec_t v;
    v.start = st;  v.ack = ack;  v.rdata = rdata;  v.ready = rdy;
    v.rv = rv;     v.rpc = rpc;
    v.e_req = e_req;   v.e_addr = e_addr;   v.e_valid = e_valid;  v.e_pc = e_pc;
    v.e_trap = e_trap; v.e_cause = e_cause; v.e_tpc = e_tpc;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic ack, input logic [31:0] rdata,
                       input logic rdy, input logic rv, input logic [31:0] rpc);
    start = st; imem_ack = ack; imem_rdata = rdata;
    out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Fields: start ack rdata ready rv rpc | req addr valid pc trap cause tpc
    vecs.push_back(mk(1,0,32'h0,    0,0,32'h0,   0,32'h000,0,32'h000,0,2'd0,32'h000)); // 0 IDLE
    vecs.push_back(mk(0,0,32'h0,    0,0,32'h0,   1,32'h000,0,32'h000,0,2'd0,32'h000)); // 1 REQ wait
    vecs.push_back(mk(0,1,32'h13,   0,0,32'h0,   1,32'h000,0,32'h000,0,2'd0,32'h000)); // 2 ack
    vecs.push_back(mk(0,0,32'h0,    1,0,32'h0,   0,32'h000,0,32'h000,0,2'd0,32'h000)); // 3 DEC
    vecs.push_back(mk(0,0,32'h0,    1,0,32'h0,   0,32'h000,1,32'h000,0,2'd0,32'h000)); // 4 OUT, ack+2
    vecs.push_back(mk(0,1,32'h93,   0,0,32'h0,   1,32'h004,0,32'h000,0,2'd0,32'h000)); // 5 REQ @4
    vecs.push_back(mk(0,0,32'h0,    1,0,32'h0,   0,32'h004,0,32'h000,0,2'd0,32'h000)); // 6 DEC
    vecs.push_back(mk(0,0,32'h0,    1,1,32'h200, 0,32'h004,1,32'h004,0,2'd0,32'h000)); // 7 OUT hs+redir
    vecs.push_back(mk(0,0,32'h0,    0,1,32'h100, 1,32'h200,0,32'h000,0,2'd0,32'h000)); // 8 REQ redir
    vecs.push_back(mk(0,0,32'h0,    0,0,32'h0,   1,32'h200,0,32'h000,0,2'd0,32'h000)); // 9 addr held
    vecs.push_back(mk(0,0,32'h0,    0,0,32'h0,   1,32'h200,0,32'h000,0,2'd0,32'h000)); // 10
    vecs.push_back(mk(0,1,32'h13,   0,0,32'h0,   1,32'h200,0,32'h000,0,2'd0,32'h000)); // 11 ack dropped
    vecs.push_back(mk(0,1,32'h33,   0,0,32'h0,   1,32'h100,0,32'h000,0,2'd0,32'h000)); // 12 refetch
    vecs.push_back(mk(0,0,32'h0,    0,0,32'h0,   0,32'h100,0,32'h000,0,2'd0,32'h000)); // 13 DEC
    vecs.push_back(mk(0,0,32'h0,    0,0,32'h0,   0,32'h100,1,32'h100,0,2'd0,32'h000)); // 14 OUT stall
    vecs.push_back(mk(0,0,32'h0,    1,1,32'h102, 0,32'h100,1,32'h100,0,2'd0,32'h000)); // 15 misalign
    vecs.push_back(mk(0,0,32'h0,    0,1,32'h300, 0,32'h100,0,32'h000,1,2'd3,32'h102)); // 16 TRAP
    vecs.push_back(mk(1,0,32'h0,    0,0,32'h0,   0,32'h100,0,32'h000,1,2'd3,32'h102)); // 17 restart
    vecs.push_back(mk(0,1,32'h13,   0,1,32'h40,  1,32'h000,0,32'h000,0,2'd0,32'h000)); // 18 ack+redir
    vecs.push_back(mk(0,1,32'h13,   0,0,32'h0,   1,32'h040,0,32'h000,0,2'd0,32'h000)); // 19 REQ @40
    vecs.push_back(mk(1,0,32'h0,    1,0,32'h0,   0,32'h040,0,32'h000,0,2'd0,32'h000)); // 20 DEC, start ign
    vecs.push_back(mk(0,0,32'h0,    1,0,32'h0,   0,32'h040,1,32'h040,0,2'd0,32'h000)); // 21 OUT hs
    vecs.push_back(mk(0,0,32'h0,    0,0,32'h0,   1,32'h044,0,32'h000,0,2'd0,32'h000)); // 22 REQ @44

    // Reset values
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("reset_outputs",
          {imem_req, imem_addr, dec_instruction, out_valid, out_instruction, out_pc,
           trap, trap_cause, trap_pc},
          {1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0});
    check("reset_perf", {perf_retired, perf_stall}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].start, vecs[i].ack, vecs[i].rdata, vecs[i].ready, vecs[i].rv, vecs[i].rpc);
      check($sformatf("vec[%0d] req/addr/valid/pc/trap/cause/tpc", i),
            {imem_req, imem_addr, out_valid, out_pc, trap, trap_cause, trap_pc},
            {vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_pc,
             vecs[i].e_trap, vecs[i].e_cause, vecs[i].e_tpc});
    end

    // Illegal word right after reset
    do_reset();
    @(negedge clk); drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clk); drive(1'b0, 1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'h0);
    @(negedge clk); drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("ill_dec_word", dec_instruction, 32'h0000_0010);
    @(negedge clk);
    check("ill_trap", {trap, trap_cause, trap_pc, imem_req, out_valid},
          {1'b1, 2'b01, 32'h0, 1'b0, 1'b0});
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("ill_restart", {imem_req, imem_addr, trap, trap_cause, trap_pc},
          {1'b1, 32'h0, 1'b0, 2'b00, 32'h0});

    // Five-cycle stall holds the output stable
    do_reset();
    @(negedge clk); drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); drive(1'b0, 1'b1, 32'h0000_00b3, 1'b0, 1'b0, 32'h0);
    @(negedge clk); drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall[%0d] valid/instr/pc", i), {out_valid, out_instruction, out_pc},
            {1'b1, 32'h0000_00b3, 32'h0});
    end
    @(negedge clk);
    check("stall_count", perf_stall, PERF ? 32'd5 : 32'd0);
    check("stall_still_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    check("retired_count", perf_retired, PERF ? 32'd1 : 32'd0);
    check("after_hs_fetch", {imem_req, imem_addr, out_valid}, {1'b1, 32'h4, 1'b0});

    // Timeout: 255 un-acked REQ cycles trap
    do_reset();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (254) @(negedge clk);
    check("tmo_last_req_cycle", {imem_req, trap}, {1'b1, 1'b0});
    @(negedge clk);
    check("tmo_trap", {trap, trap_cause, trap_pc, imem_req}, {1'b1, 2'b10, 32'h0, 1'b0});

    // Ack on the 255th cycle wins over timeout
    do_reset();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (254) @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    @(negedge clk); imem_ack = 1'b0;
    check("tmo_ack_wins_dec", {trap, imem_req, dec_instruction}, {1'b0, 1'b0, 32'h13});
    @(negedge clk);
    check("tmo_ack_wins_out", {trap, out_valid, out_pc}, {1'b0, 1'b1, 32'h0});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_decode_ctrl.md
Name: fetch_decode_ctrl

Overview:
Sequencer in front of the RV32 instruction decoder. Owns the PC and fetches words from instruction memory over a req/ack handshake. Presents each word to the decoder, checks the decoder's invalid flag, and hands valid instructions to the execute stage over a valid/ready handshake. Handles branch redirects, memory timeouts and traps. One instruction is in flight at a time.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded at reset and on restart from TRAP
TIMEOUT_CYCLES, 255, maximum cycles in REQ without imem_ack before a timeout trap (must be >= 1)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; leaves IDLE or TRAP
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  32  fetch address (= pc), stable while imem_req=1
imem_ack  in  1  fetch completes in the cycle where imem_req && imem_ack
imem_rdata  in  32  instruction word, valid with imem_ack
dec_instruction  out  32  registered word driven to the decoder
dec_invalid  in  1  decoder flag: instruction[1:0] != 2'b11
out_valid  out  1  instruction available to execute
out_ready  in  1  execute accepts when out_valid && out_ready
out_instruction  out  32  equals dec_instruction
out_pc  out  32  PC of out_instruction
redirect_valid  in  1  branch/jump redirect, single-cycle pulse
redirect_pc  in  32  redirect target
trap  out  1  sticky trap indicator
trap_cause  out  2  01 illegal, 10 fetch timeout, 11 misaligned redirect
trap_pc  out  32  PC associated with the trap

Behaviour:
- Reset (async, any state): state=IDLE, pc=RESET_PC, timeout count=0, redirect-pending=0; every output 0 except imem_addr=RESET_PC.
- States: IDLE, REQ, DEC, OUT, TRAP.
- IDLE: imem_req=0. start -> REQ.
- REQ: imem_req=1, imem_addr=pc.
  - On ack: latch imem_rdata into instr_q; go to DEC, or back to REQ if redirect is pending (data discarded, pending cleared).
  - Timeout counter increments each REQ cycle without ack and clears on ack or leaving REQ.
  - Counter reaching TIMEOUT_CYCLES -> TRAP, cause 10, trap_pc=pc. Ack in the same cycle wins over timeout.
- DEC (one cycle): dec_invalid=1 -> TRAP, cause 01, trap_pc=pc. Otherwise -> OUT.
- OUT: out_valid=1; out_instruction and out_pc held stable until handshake. On handshake: pc<=pc+4 (wraps modulo 2^32) -> REQ.
- Latency: ack at cycle N gives out_valid at N+2. With out_ready=1 the next imem_req is at N+3.
- Redirect, all states except IDLE/TRAP:
  - redirect_pc[1:0]!=0 -> TRAP, cause 11, trap_pc=redirect_pc.
  - Otherwise pc<=redirect_pc.
  - REQ without ack: imem_addr does not change; set redirect-pending and re-fetch after ack.
  - REQ with ack in the same cycle: discard data -> REQ at the new pc.
  - DEC/OUT: drop the held word, out_valid falls next cycle -> REQ.
  - Redirect and out handshake in the same cycle: the instruction counts as consumed, pc=redirect_pc (not +4).
- Redirect in IDLE/TRAP: ignored.
- TRAP: trap=1; trap_cause/trap_pc held; imem_req=0, out_valid=0. start -> pc=RESET_PC, trap/trap_cause/trap_pc cleared -> REQ.
- start outside IDLE/TRAP: ignored.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds 32-bit saturating counters perf_retired (out handshakes) and perf_stall (cycles with out_valid && !out_ready), reset to 0.
- Not defined: perf_retired and perf_stall ports exist but are tied to 0, and no counter flops are built.

Decomposition:
- Package fetch_ctrl_pkg: state encoding, trap cause codes (CAUSE_ILLEGAL=2'b01, CAUSE_TIMEOUT=2'b10, CAUSE_MISALIGN=2'b11), PC increment constant 4.
- Sub-module fetch_timeout_counter: clear/enable inputs, expired output, width $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Reset then start, memory acks after 1 cycle with 32'h0000_0013, out_ready=1 -> out_valid at ack+2, out_pc=0, next imem_addr=4.
- out_ready low for 5 cycles -> out_instruction/out_pc stable for all 5; perf_stall=5 when FETCH_PERF_CNT_EN is defined.
- Word 32'h0000_0010 (low bits 00), decoder flags invalid -> trap=1, cause 01, trap_pc=0; start -> fetch from RESET_PC.
- Redirect to 32'h100 during REQ, ack 3 cycles later -> imem_addr stays 0 until ack, ack data dropped, next request at 32'h100.
- Redirect to 32'h102 -> cause 11, trap_pc=32'h102. No ack for 255 cycles -> cause 10.
- Redirect to 32'h200 in the same cycle as an out handshake -> next imem_addr 32'h200, not pc+4.
